// File: rtl/ni_code_packer.sv
// Packs NUM_BITS neighbour-comparison bits into one NI code and hands it downstream over valid/ready.
// Define NI_PACK_ROTINV_EN to output the rotation-invariant (minimum circular rotation) code instead of the raw one.
module ni_code_packer #(
  parameter int NUM_BITS      = 8,
  parameter int PIX_PER_FRAME = 307200,
  parameter int CNT_W         = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start_i,
  input  logic                done_i,
  input  logic                bit_i,
  input  logic                code_ready_i,
  output logic [NUM_BITS-1:0] code_o,
  output logic                code_valid_o,
  output logic                frame_done_o,
  output logic                overflow_o
);

  localparam int BC_W = $clog2(NUM_BITS);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_FRAME - 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] acc_q, acc_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [NUM_BITS-1:0] code_q, code_d;
  logic                code_valid_q, code_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;

  logic                hs, out_free;
  logic [NUM_BITS-1:0] full_code, mapped_code;

  assign hs        = code_valid_q & code_ready_i;
  assign out_free  = ~code_valid_q | code_ready_i;
  assign full_code = {acc_q[NUM_BITS-2:0], bit_i};

`ifdef NI_PACK_ROTINV_EN
  // Left-rotate by every amount and keep a running minimum; purely combinational on the load path.
  logic [NUM_BITS-1:0][NUM_BITS-1:0] rot, run_min;
  for (genvar r = 0; r < NUM_BITS; r++) begin : g_rot
    if (r == 0) begin : g_id
      assign rot[r]     = full_code;
      assign run_min[r] = full_code;
    end else begin : g_r
      assign rot[r]     = {full_code[NUM_BITS-1-r:0], full_code[NUM_BITS-1:NUM_BITS-r]};
      assign run_min[r] = (rot[r] < run_min[r-1]) ? rot[r] : run_min[r-1];
    end
  end
  assign mapped_code = run_min[NUM_BITS-1];
`else
  assign mapped_code = full_code;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (frame_start_i) begin
      // Restart wins over any handshake or bit this cycle; overflow is deliberately kept.
      state_d      = COLLECT;
      acc_d        = '0;
      bit_cnt_d    = '0;
      pix_cnt_d    = '0;
      code_valid_d = 1'b0;
    end else begin
      if (hs) begin
        code_valid_d = 1'b0;
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        COLLECT: begin
          if (done_i) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (out_free) begin
                code_d       = mapped_code;
                code_valid_d = 1'b1;
                acc_d        = '0;
                bit_cnt_d    = '0;
              end else begin
                acc_d   = mapped_code;
                state_d = HOLD;
              end
            end else begin
              acc_d     = full_code;
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            code_d       = acc_q;
            code_valid_d = 1'b1;
            state_d      = COLLECT;
            // A bit arriving in the freeing cycle starts the next pixel.
            if (done_i) begin
              acc_d     = {{(NUM_BITS-1){1'b0}}, bit_i};
              bit_cnt_d = BC_W'(1);
            end else begin
              acc_d     = '0;
              bit_cnt_d = '0;
            end
          end else if (done_i) begin
            overflow_d = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= COLLECT;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign code_o       = code_q;
  assign code_valid_o = code_valid_q;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ni_code_packer.sv
// Scoreboard bench for ni_code_packer (NUM_BITS=8, PIX_PER_FRAME=4); expected codes follow NI_PACK_ROTINV_EN.
module tb_ni_code_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start_i = 1'b0;
  logic       done_i = 1'b0;
  logic       bit_i = 1'b0;
  logic       code_ready_i = 1'b0;
  logic [7:0] code_o;
  logic       code_valid_o;
  logic       frame_done_o;
  logic       overflow_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

`ifdef NI_PACK_ROTINV_EN
  localparam logic [7:0] E_B2 = 8'h2B, E_FF = 8'hFF, E_01 = 8'h01, E_80 = 8'h01,
                         E_3C = 8'h0F, E_55 = 8'h55, E_A5 = 8'h2D, E_0F = 8'h0F;
`else
  localparam logic [7:0] E_B2 = 8'hB2, E_FF = 8'hFF, E_01 = 8'h01, E_80 = 8'h80,
                         E_3C = 8'h3C, E_55 = 8'h55, E_A5 = 8'hA5, E_0F = 8'h0F;
`endif

  ni_code_packer #(.NUM_BITS(8), .PIX_PER_FRAME(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .frame_start_i(frame_start_i), .done_i(done_i), .bit_i(bit_i),
    .code_ready_i(code_ready_i), .code_o(code_o), .code_valid_o(code_valid_o),
    .frame_done_o(frame_done_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted code is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && code_valid_o && code_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected act=%0h exp=none t=%0t", code_o, $time);
      end else begin
        chk("sb_code", {24'd0, code_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Bits go out MSB first on consecutive cycles; done_i drops after the last.
  task automatic send_bits(input logic [7:0] c, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(posedge clk); #1;
      done_i = 1'b1; bit_i = c[i];
    end
    @(posedge clk); #1;
    done_i = 1'b0; bit_i = 1'b0;
  endtask

  task automatic pulse_frame_start();
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
  endtask

  // Send one code with ready high and check the frame_done pulse that follows its handshake.
  task automatic send_fd(input logic [7:0] raw, input logic [7:0] exp, input logic fd);
    exp_q.push_back(exp);
    send_bits(raw, 8);
    @(negedge clk);
    @(negedge clk); chk("frame_done", {31'd0, frame_done_o}, {31'd0, fd});
    @(negedge clk); chk("frame_done_off", {31'd0, frame_done_o}, 32'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    // 1: reset with done_i toggling
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 done_i = ~done_i; bit_i = 1'b1;
    end
    @(negedge clk);
    chk("rst_valid", {31'd0, code_valid_o}, 32'd0);
    chk("rst_code", {24'd0, code_o}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b1; done_i = 1'b0; bit_i = 1'b0;

    // 2: basic pack, latency 1, valid for one cycle
    code_ready_i = 1'b1;
    exp_q.push_back(E_B2);
    send_bits(8'hB2, 8);
    @(negedge clk);
    chk("lat_valid", {31'd0, code_valid_o}, 32'd1);
    chk("lat_code", {24'd0, code_o}, {24'd0, E_B2});
    @(negedge clk);
    chk("one_cycle_valid", {31'd0, code_valid_o}, 32'd0);

    // 3: backpressure, HOLD, dropped bit
    @(posedge clk); #1 code_ready_i = 1'b0;
    exp_q.push_back(E_B2);
    exp_q.push_back(E_FF);
    send_bits(8'hB2, 8);
    send_bits(8'hFF, 8);
    @(negedge clk);
    chk("hold_no_ovf", {31'd0, overflow_o}, 32'd0);
    send_bits(8'h80, 1);
    @(negedge clk);
    chk("ovf_set", {31'd0, overflow_o}, 32'd1);
    chk("held_code", {24'd0, code_o}, {24'd0, E_B2});
    chk("held_valid", {31'd0, code_valid_o}, 32'd1);
    @(posedge clk); #1 code_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_valid", {31'd0, code_valid_o}, 32'd1);
    chk("b2b_code", {24'd0, code_o}, {24'd0, E_FF});
    wait_drain();
    chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // 4: frame count, pulse on 4th and 8th handshake
    pulse_frame_start();
    send_fd(8'h3C, E_3C, 1'b0);
    send_fd(8'h55, E_55, 1'b0);
    send_fd(8'hA5, E_A5, 1'b0);
    send_fd(8'h0F, E_0F, 1'b1);
    send_fd(8'hB2, E_B2, 1'b0);
    send_fd(8'hFF, E_FF, 1'b0);
    send_fd(8'h80, E_80, 1'b0);
    send_fd(8'h01, E_01, 1'b1);

    // 5: frame restart discards partial bits and pixel count
    send_fd(8'h55, E_55, 1'b0);
    send_bits(8'hE0, 3);
    pulse_frame_start();
    chk("fs_keeps_ovf", {31'd0, overflow_o}, 32'd1);
    send_fd(8'h01, E_01, 1'b0);
    send_fd(8'h3C, E_3C, 1'b0);
    send_fd(8'hA5, E_A5, 1'b0);
    send_fd(8'hFF, E_FF, 1'b1);

    // 6: contiguous codes at full rate, rotation-mapped when enabled
    exp_q.push_back(E_B2);
    exp_q.push_back(E_80);
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk); #1 done_i = 1'b1; bit_i = 8'hB2 >> i;
    end
    send_bits(8'h80, 8);
    @(negedge clk);
    chk("rot_code_lat", {24'd0, code_o}, {24'd0, E_80});
    wait_drain();

    // Final reset clears the sticky overflow
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst2_overflow", {31'd0, overflow_o}, 32'd0);
    chk("rst2_valid", {31'd0, code_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ni_code_packer.md
Name: ni_code_packer

Overview:
- Downstream neighbour of the NIRD comparison stage.
- Each `done_i` pulse carries one neighbour comparison bit. The block packs every `NUM_BITS` consecutive bits into one NI code word.
- Codes go out through a valid/ready handshake with a one-code holding buffer.
- Counts accepted codes per frame, pulses `frame_done_o` at the end of a frame, and flags a dropped bit with a sticky overflow.

Parameters:
- NUM_BITS, 8, comparison bits per code (neighbours per pixel); range 2..16.
- PIX_PER_FRAME, 307200, codes per frame; the frame counter wraps at this value.
- CNT_W, 19, width of the pixel counter; must satisfy 2^CNT_W >= PIX_PER_FRAME.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- frame_start_i  in  1  one-cycle pulse; clears partial code, pending output and pixel count.
- done_i  in  1  bit strobe; driven by the comparison stage's registered done.
- bit_i  in  1  comparison bit; valid while done_i=1.
- code_ready_i  in  1  downstream ready.
- code_o  out  NUM_BITS  packed code.
- code_valid_o  out  1  code_o valid.
- frame_done_o  out  1  one-cycle pulse after the last code of a frame is accepted.
- overflow_o  out  1  sticky; a bit arrived while no storage was free.

Behaviour:
- Reset (rst=0 at an edge):
  - code_valid_o=0, code_o=0, frame_done_o=0, overflow_o=0.
  - Accumulator, bit counter and pixel counter are 0; FSM enters COLLECT.
  - Reset mid-operation discards everything.
- Priority: rst > frame_start_i > done_i.
- Bit order: the first bit of a pixel lands in code bit NUM_BITS-1, the last bit in bit 0. The accumulator shifts left and inserts bit_i at the LSB.
- FSM has two states: COLLECT and HOLD.
- COLLECT:
  - Each done_i shifts bit_i into the accumulator and increments the bit counter.
  - On the NUM_BITS-th bit, the completed code is {acc[NUM_BITS-2:0], bit_i}.
  - If the output register is free (code_valid_o=0, or code_valid_o & code_ready_i this cycle), the code loads into code_o. code_valid_o is 1 on the next cycle (latency 1 from the last done_i). The bit counter returns to 0 and the FSM stays in COLLECT.
  - Otherwise the completed code stays in the accumulator and the FSM goes to HOLD.
- HOLD:
  - When the output register frees (handshake), the accumulator moves into code_o in the same edge. The bit counter clears and the FSM returns to COLLECT.
  - A done_i while in HOLD is dropped and sets overflow_o=1. Exception: a done_i in the freeing cycle itself is accepted as bit 1 of the next pixel.
- Output register: code_o is stable while code_valid_o=1 and code_ready_i=0. A back-to-back handshake plus reload in one cycle is allowed (full throughput of 1 code/cycle when NUM_BITS bits arrive contiguously).
- Pixel counter:
  - Increments on each handshake (code_valid_o & code_ready_i).
  - At PIX_PER_FRAME-1 plus a handshake, it wraps to 0 and frame_done_o=1 on the next cycle, for exactly one cycle.
- frame_start_i:
  - Clears the accumulator, bit counter and pixel counter, sets code_valid_o=0, and puts the FSM in COLLECT.
  - overflow_o is not cleared; only rst clears it.
  - A done_i in the same cycle is ignored.
- frame_start_i and a handshake in the same cycle: the handshake is not counted.
- Width: all counters are unsigned; no arithmetic on code bits apart from the optional feature.

Optional Feature:
- Macro: NI_PACK_ROTINV_EN.
- Defined:
  - Every completed code is replaced by its minimum over all NUM_BITS circular rotations before loading into code_o. This gives a rotation-invariant descriptor.
  - The rotation is combinational on the load path, so latency is unchanged (still 1 cycle).
  - HOLD stores the already-mapped code.
- Undefined: the raw packed code is output.

Test Plan (NUM_BITS=8, PIX_PER_FRAME=4 unless stated):
1. Reset: hold rst=0 for 2 cycles with done_i toggling -> code_valid_o=0, frame_done_o=0, overflow_o=0; after release, the first 8 bits form a fresh code.
2. Basic pack: code_ready_i=1, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> code_o=8'hB2 with code_valid_o=1 for exactly one cycle, 1 cycle after the 8th bit.
3. Backpressure and overflow:
   - Stimulus: code_ready_i=0; send bits for 8'hB2, then 8'hFF, then one extra bit; then raise code_ready_i.
   - Response: B2 held on code_o; FF in HOLD; the extra bit sets overflow_o=1 and is dropped.
   - After raising code_ready_i: B2 then FF on consecutive cycles, and overflow_o stays 1.
4. Frame count: 4 codes accepted with code_ready_i=1 -> frame_done_o=1 for one cycle after the 4th handshake; a 5th code does not pulse it; after 8 codes, a second pulse.
5. Frame restart: 3 bits sent, then frame_start_i, then bits 0,0,0,0,0,0,0,1 -> code_o=8'h01; the partial bits are discarded and the pixel count restarts at 0.
6. NI_PACK_ROTINV_EN defined: pack bits of 8'hB2 -> code_o=8'h2B; pack 8'h80 -> code_o=8'h01; latency still 1 cycle.
